// File: rtl/la_capture_writer.sv
// ---------------------------------------------------------------------------
// la_capture_writer
//
// Write-side capture controller for the logic-analyzer sample RAM
// (DATA_W x 2**ADDR_W simple dual-port). The incoming sample stream is
// written into the RAM as a circular buffer. A programmable pre-trigger
// window is filled first, then the trigger sample is written, and then the
// post-trigger window is filled. When the capture stops, the RAM holds
// exactly one frame of DEPTH samples. The trigger address and the
// frame-start address are reported to the read-side unloader.
//
// Optional feature (off by default):
//   LA_CAPTURE_DECIM_EN - adds the decim_div input. Only every
//                         (decim_div+1)-th smp_valid is treated as a sample.
//
// Ports
//   wr_clk       in   capture clock, shared with the RAM write port
//   tb_wr_rst    in   asynchronous active-high reset
//   arm          in   pulse: start a capture (honoured in IDLE or DONE only)
//   abort        in   pulse: return to IDLE from any state (wins over arm)
//   pre_depth    in   pre-trigger sample count, latched on an accepted arm
//   decim_div    in   decimation divider (LA_CAPTURE_DECIM_EN builds only)
//   trig         in   trigger qualifier, meaningful only with smp_valid
//   smp_valid    in   sample strobe
//   smp_data     in   sample value
//   ram_wr_en    out  RAM write enable (registered)
//   ram_wr_addr  out  RAM write address (registered)
//   ram_wr_data  out  RAM write data (registered)
//   busy         out  1 while in PRE, WAIT_TRIG or POST
//   done         out  1 in DONE until the next accepted arm, abort or reset
//   trig_addr    out  address of the trigger sample
//   start_addr   out  address of the oldest sample in the frame
// ---------------------------------------------------------------------------
module la_capture_writer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              wr_clk,
    input  logic              tb_wr_rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_depth,
`ifdef LA_CAPTURE_DECIM_EN
    input  logic [15:0]       decim_div,
`endif
    input  logic              trig,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] pre_lat;
    logic [ADDR_W-1:0] post_load;
    logic              in_capture;
    logic              sample_ok;
    logic              arm_ok;

    // An arm is only accepted from a resting state, and abort overrides it.
    assign in_capture = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    assign arm_ok     = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));

    // Post-trigger length makes pre + trigger + post fill the whole RAM.
    assign post_load  = ADDR_MAX - pre_lat;

    // Oldest sample of the frame; modulo DEPTH via natural ADDR_W wrap.
    assign start_addr = trig_addr - pre_lat;

`ifdef LA_CAPTURE_DECIM_EN
    logic [15:0] div_lat;
    logic [15:0] phase;

    // Only the first strobe of each (div+1)-long phase cycle is kept, so a
    // trigger on a dropped strobe is never seen by the FSM.
    assign sample_ok = smp_valid && (phase == 16'd0);

    // Decimation phase counter, restarted on every accepted arm and stepped
    // on every strobe (kept or dropped) while a capture is running.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            div_lat <= 16'd0;
            phase   <= 16'd0;
        end else if (arm_ok) begin
            div_lat <= decim_div;
            phase   <= 16'd0;
        end else if (in_capture && smp_valid && !abort) begin
            phase <= (phase == div_lat) ? 16'd0 : phase + 16'd1;
        end
    end
`else
    assign sample_ok = smp_valid;
`endif

    // Capture FSM with registered RAM write port and status outputs.
    // Every kept sample in PRE/WAIT_TRIG/POST is written at wp one cycle
    // later; the FSM only counts those writes to decide when to move on.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state       <= ST_IDLE;
            wp          <= ADDR_ZERO;
            cnt         <= ADDR_ZERO;
            post_cnt    <= ADDR_ZERO;
            pre_lat     <= ADDR_ZERO;
            trig_addr   <= ADDR_ZERO;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= ADDR_ZERO;
            ram_wr_data <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                if (in_capture && sample_ok) begin
                    ram_wr_en   <= 1'b1;
                    ram_wr_addr <= wp;
                    ram_wr_data <= smp_data;
                    wp          <= wp + ADDR_ONE;
                end
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm_ok) begin
                            pre_lat  <= pre_depth;
                            wp       <= ADDR_ZERO;
                            cnt      <= ADDR_ZERO;
                            post_cnt <= ADDR_ZERO;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= (pre_depth != ADDR_ZERO) ? ST_PRE : ST_WAIT_TRIG;
                        end
                    end
                    ST_PRE: begin
                        if (sample_ok) begin
                            cnt <= cnt + ADDR_ONE;
                            if ((cnt + ADDR_ONE) == pre_lat) begin
                                state <= ST_WAIT_TRIG;
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (sample_ok && trig) begin
                            trig_addr <= wp;
                            post_cnt  <= post_load;
                            if (post_load == ADDR_ZERO) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample_ok) begin
                            post_cnt <= post_cnt - ADDR_ONE;
                            if (post_cnt == ADDR_ONE) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_la_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_la_capture_writer
//
// Self-checking bench for la_capture_writer. Expected RAM writes
// ({addr, data}) are queued as samples are driven, and a monitor pops and
// compares them whenever the DUT asserts ram_wr_en. Build with
// LA_CAPTURE_DECIM_EN defined to also exercise the decimation option.
// ---------------------------------------------------------------------------
module tb_la_capture_writer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2048;

    logic              wr_clk;
    logic              tb_wr_rst;
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] pre_depth;
`ifdef LA_CAPTURE_DECIM_EN
    logic [15:0]       decim_div;
`endif
    logic              trig;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int n_cmp;
    int n_err;
    int wr_count;

    la_capture_writer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .wr_clk      (wr_clk),
        .tb_wr_rst   (tb_wr_rst),
        .arm         (arm),
        .abort       (abort),
        .pre_depth   (pre_depth),
`ifdef LA_CAPTURE_DECIM_EN
        .decim_div   (decim_div),
`endif
        .trig        (trig),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .busy        (busy),
        .done        (done),
        .trig_addr   (trig_addr),
        .start_addr  (start_addr)
    );

    // 100 MHz capture clock.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Write monitor: sampled on the falling edge, every write must match the
    // oldest queued expectation; a write with nothing queued is an error.
    initial begin
        forever begin
            @(negedge wr_clk);
            if (!tb_wr_rst && ram_wr_en === 1'b1) begin
                wr_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                             ram_wr_addr, ram_wr_data);
                end else begin
                    logic [ADDR_W+DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if ({ram_wr_addr, ram_wr_data} !== e) begin
                        n_err++;
                        $display("[TB] FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 ram_wr_addr, ram_wr_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    // Drive one clock cycle of sample inputs, returning 1 time unit after
    // the edge that consumed them.
    task automatic applyStimulus(input logic v, input logic t, input logic [DATA_W-1:0] d);
        smp_valid = v;
        trig      = t;
        smp_data  = d;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic pulse_arm(input logic [ADDR_W-1:0] p, input logic with_abort);
        smp_valid = 1'b0;
        trig      = 1'b0;
        pre_depth = p;
        arm       = 1'b1;
        abort     = with_abort;
        @(posedge wr_clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    // Drive n_valid samples (data 0xFF downcounting) with the real trigger
    // on valid index trig_at. Writes are expected for indices up to
    // trig_at + (DEPTH-1-pre), at address index mod DEPTH.
    task automatic drive_frame(input int pre, input int trig_at, input int n_valid,
                               input bit pre_noise, input bit gaps,
                               output logic done_after_trig);
        int last_idx;
        logic [DATA_W-1:0] d;
        last_idx = trig_at + (DEPTH - 1 - pre);
        done_after_trig = 1'b0;
        for (int v = 0; v < n_valid; v++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            d = 8'hFF - 8'(v);
            if (v <= last_idx) exp_q.push_back({11'(v), d});
            applyStimulus(1'b1, (v == trig_at) || (pre_noise && v < pre), d);
            if (v == trig_at) done_after_trig = done;
        end
    endtask

    task automatic test_reset();
        logic dat;
        $display("[TB] test_reset");
        n_cmp++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data, busy, done, trig_addr, start_addr} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_state: got en=%b addr=%0d data=%02h busy=%b done=%b trig=%0d start=%0d, required all 0",
                     ram_wr_en, ram_wr_addr, ram_wr_data, busy, done, trig_addr, start_addr);
        end
        wr_count = 0;
        pulse_arm(11'd8, 1'b0);
        drive_frame(8, 10, 30, 1'b0, 1'b0, dat);
        // Mid-POST: reset must clear outputs without waiting for an edge.
        tb_wr_rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_wr_en, ram_wr_addr, ram_wr_data, busy, done, trig_addr, start_addr} !== '0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got en=%b addr=%0d data=%02h busy=%b done=%b trig=%0d start=%0d, required all 0",
                     ram_wr_en, ram_wr_addr, ram_wr_data, busy, done, trig_addr, start_addr);
        end
        exp_q.delete();
        repeat (2) @(posedge wr_clk);
        #1;
        tb_wr_rst = 1'b0;
        // Without a new arm, strobes and triggers must not cause writes.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, required busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic dat;
        $display("[TB] test_basic");
        wr_count = 0;
        pulse_arm(11'd16, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL basic_busy: got %b, required 1", busy);
        end
        drive_frame(16, 99, 99 + 2032 + 10, 1'b0, 1'b1, dat);
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_status: got done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        n_cmp++;
        if (trig_addr !== 11'd99 || start_addr !== 11'd83) begin
            n_err++;
            $display("[TB] FAIL basic_addrs: got trig=%0d start=%0d, required trig=99 start=83", trig_addr, start_addr);
        end
        n_cmp++;
        if (wr_count !== 2131 || exp_q.size() !== 0) begin
            n_err++;
            $display("[TB] FAIL basic_count: got writes=%0d pending=%0d, required writes=2131 pending=0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_zero_pre();
        logic dat;
        $display("[TB] test_zero_pre");
        wr_count = 0;
        pulse_arm(11'd0, 1'b0);
        drive_frame(0, 0, DEPTH + 10, 1'b0, 1'b0, dat);
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (done !== 1'b1 || trig_addr !== 11'd0 || start_addr !== 11'd0) begin
            n_err++;
            $display("[TB] FAIL zero_pre: got done=%b trig=%0d start=%0d, required done=1 trig=0 start=0", done, trig_addr, start_addr);
        end
        n_cmp++;
        if (wr_count !== DEPTH || exp_q.size() !== 0) begin
            n_err++;
            $display("[TB] FAIL zero_pre_count: got writes=%0d pending=%0d, required writes=2048 pending=0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_max_pre();
        logic dat;
        $display("[TB] test_max_pre");
        wr_count = 0;
        pulse_arm(11'd2047, 1'b0);
        drive_frame(2047, 3000, 3010, 1'b1, 1'b0, dat);
        n_cmp++;
        if (dat !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL max_pre_done_timing: got done=%b right after trigger, required 1", dat);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (trig_addr !== 11'd952 || start_addr !== 11'd953) begin
            n_err++;
            $display("[TB] FAIL max_pre_addrs: got trig=%0d start=%0d, required trig=952 start=953", trig_addr, start_addr);
        end
        n_cmp++;
        if (wr_count !== 3001 || exp_q.size() !== 0) begin
            n_err++;
            $display("[TB] FAIL max_pre_count: got writes=%0d pending=%0d, required writes=3001 pending=0", wr_count, exp_q.size());
        end
    endtask

    task automatic test_control();
        $display("[TB] test_control");
        wr_count = 0;
        // arm+abort together from DONE: abort wins, pre_depth is not latched.
        pulse_arm(11'd5, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || start_addr !== 11'd953) begin
            n_err++;
            $display("[TB] FAIL arm_abort: got busy=%b done=%b start=%0d, required busy=0 done=0 start=953", busy, done, start_addr);
        end
        // Capture into WAIT_TRIG, then a busy arm that must be ignored.
        pulse_arm(11'd4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({11'(i), 8'(8'h40 + i)});
            applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
        end
        pulse_arm(11'd100, 1'b0);
        for (int i = 6; i < 8; i++) begin
            exp_q.push_back({11'(i), 8'(8'h40 + i)});
            applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL busy_arm: got busy=%b, required 1", busy);
        end
        // Abort with a valid triggering sample in the same cycle: no write.
        abort = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'hAA);
        abort = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || trig_addr !== 11'd952 || start_addr !== 11'd948) begin
            n_err++;
            $display("[TB] FAIL abort: got busy=%b done=%b trig=%0d start=%0d, required busy=0 done=0 trig=952 start=948",
                     busy, done, trig_addr, start_addr);
        end
        n_cmp++;
        if (wr_count !== 8 || exp_q.size() !== 0) begin
            n_err++;
            $display("[TB] FAIL control_count: got writes=%0d pending=%0d, required writes=8 pending=0", wr_count, exp_q.size());
        end
    endtask

`ifdef LA_CAPTURE_DECIM_EN
    task automatic test_decim();
        int k;
        $display("[TB] test_decim");
        wr_count  = 0;
        decim_div = 16'd3;
        pulse_arm(11'd4, 1'b0);
        // Kept samples are v=0,4,8,...; triggers on v=5 and v=17 fall on
        // dropped strobes, the one on v=20 (kept sample 5) is real.
        for (int v = 0; v < 8220; v++) begin
            k = v / 4;
            if ((v % 4) == 0 && k <= 5 + (DEPTH - 1 - 4)) exp_q.push_back({11'(k), 8'(v)});
            applyStimulus(1'b1, (v == 5) || (v == 17) || (v == 20), 8'(v));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (done !== 1'b1 || trig_addr !== 11'd5 || start_addr !== 11'd1) begin
            n_err++;
            $display("[TB] FAIL decim_addrs: got done=%b trig=%0d start=%0d, required done=1 trig=5 start=1", done, trig_addr, start_addr);
        end
        n_cmp++;
        if (wr_count !== 2049 || exp_q.size() !== 0) begin
            n_err++;
            $display("[TB] FAIL decim_count: got writes=%0d pending=%0d, required writes=2049 pending=0", wr_count, exp_q.size());
        end
        decim_div = 16'd0;
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        wr_count  = 0;
        tb_wr_rst = 1'b1;
        arm       = 1'b0;
        abort     = 1'b0;
        pre_depth = '0;
        trig      = 1'b0;
        smp_valid = 1'b0;
        smp_data  = '0;
`ifdef LA_CAPTURE_DECIM_EN
        decim_div = 16'd0;
`endif
        repeat (3) @(posedge wr_clk);
        #1;
        tb_wr_rst = 1'b0;
        @(posedge wr_clk);
        #1;
        test_reset();
        test_basic();
        test_zero_pre();
        test_max_pre();
        test_control();
`ifdef LA_CAPTURE_DECIM_EN
        test_decim();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
